// File: rtl/wash_cycle_sequencer.sv
// Washing-machine programme sequencer: fill, wash, drain, rinse xN, spin, done.
// Optional agitation pause is built only when WM_PAUSE_EN is defined.
module wash_cycle_sequencer #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WASH_CYC  = 30,
  parameter int unsigned RINSE_CYC = 30,
  parameter int unsigned SPIN_CYC  = 30,
  parameter int unsigned N_RINSE   = 2,
  parameter int unsigned FILL_TMO  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clothes,
  input  logic       det_liquid,
  input  logic       water_tap,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       pause,
  input  logic       clear_err,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       busy,
  output logic       finish,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FILL_W  = 4'd1,
    S_WASH    = 4'd2,
    S_DRAIN_W = 4'd3,
    S_FILL_R  = 4'd4,
    S_RINSE   = 4'd5,
    S_DRAIN_R = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(FILL_TMO - 1);
  localparam logic [1:0]       LAST_RINSE = 2'(N_RINSE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       rinse_q, rinse_d;
  logic [1:0]       err_q, err_d;
  logic             hold;
  logic             tmo;

`ifdef WM_PAUSE_EN
  assign hold = pause && (state_q == S_WASH || state_q == S_RINSE || state_q == S_SPIN);
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  assign tmo = (timer_q == TMO_LAST);

  // Sensors are tested before the timeout so a coincident sensor wins.
  always_comb begin
    state_d = state_q;
    rinse_d = rinse_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        rinse_d = '0;
        if (start && clothes && det_liquid) begin
          if (water_tap) begin
            state_d = S_FILL_W;
          end else begin
            state_d = S_ERROR;
            err_d   = 2'b11;
          end
        end
      end
      S_FILL_W: begin
        if (level_full)  state_d = S_WASH;
        else if (tmo)    begin state_d = S_ERROR; err_d = 2'b01; end
      end
      S_WASH:  if (!hold && timer_q == WASH_LAST)  state_d = S_DRAIN_W;
      S_DRAIN_W: begin
        if (level_empty) state_d = S_FILL_R;
        else if (tmo)    begin state_d = S_ERROR; err_d = 2'b10; end
      end
      S_FILL_R: begin
        if (level_full)  state_d = S_RINSE;
        else if (tmo)    begin state_d = S_ERROR; err_d = 2'b01; end
      end
      S_RINSE: if (!hold && timer_q == RINSE_LAST) state_d = S_DRAIN_R;
      S_DRAIN_R: begin
        if (level_empty) begin
          if (rinse_q == LAST_RINSE) begin
            state_d = S_SPIN;
          end else begin
            state_d = S_FILL_R;
            rinse_d = rinse_q + 2'd1;
          end
        end else if (tmo) begin
          state_d = S_ERROR;
          err_d   = 2'b10;
        end
      end
      S_SPIN:  if (!hold && timer_q == SPIN_LAST)  state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        rinse_d = '0;
      end
      S_ERROR: begin
        if (clear_err && level_empty) begin
          state_d = S_IDLE;
          err_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)            timer_d = '0;
    else if (hold || timer_q == '1)    timer_d = timer_q;
    else                               timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rinse_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rinse_q <= rinse_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    motor_on    = 1'b0;
    motor_fast  = 1'b0;
    door_lock   = 1'b1;
    busy        = 1'b1;
    finish      = 1'b0;
    error       = 1'b0;
    case (state_q)
      S_IDLE:    begin door_lock = 1'b0; busy = 1'b0; end
      S_FILL_W, S_FILL_R:   fill_valve  = 1'b1;
      S_DRAIN_W, S_DRAIN_R: drain_valve = 1'b1;
      S_WASH, S_RINSE:      motor_on    = !hold;
      S_SPIN: begin
        drain_valve = 1'b1;
        motor_on    = !hold;
        motor_fast  = !hold;
      end
      S_DONE:    begin door_lock = 1'b0; busy = 1'b0; finish = 1'b1; end
      S_ERROR: begin
        busy        = 1'b0;
        error       = 1'b1;
        drain_valve = !level_empty;
        door_lock   = !level_empty;
      end
      default:   begin door_lock = 1'b0; busy = 1'b0; end
    endcase
    err_code = err_q;
    phase    = state_q;
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer; honours WM_PAUSE_EN for the pause scenario.
module tb_wash_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, clothes = 1'b0, det_liquid = 1'b0, water_tap = 1'b0;
  logic       level_full = 1'b0, level_empty = 1'b0, pause = 1'b0, clear_err = 1'b0;
  logic       fill_valve, drain_valve, motor_on, motor_fast, door_lock, busy, finish, error;
  logic [1:0] err_code;
  logic [3:0] phase;

  int n_checks = 0;
  int n_pass   = 0;
  bit env_on   = 1'b0;
  int fv_cnt   = 0;
  int dv_cnt   = 0;

  wash_cycle_sequencer #(
    .CNT_W(8), .WASH_CYC(4), .RINSE_CYC(3), .SPIN_CYC(2), .N_RINSE(2), .FILL_TMO(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clothes(clothes), .det_liquid(det_liquid),
    .water_tap(water_tap), .level_full(level_full), .level_empty(level_empty),
    .pause(pause), .clear_err(clear_err), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .motor_on(motor_on), .motor_fast(motor_fast),
    .door_lock(door_lock), .busy(busy), .finish(finish), .error(error),
    .err_code(err_code), .phase(phase)
  );

  always #5 clk = ~clk;

  // Drum model: sensor reports full/empty on the 2nd cycle a valve is seen open.
  task automatic tick();
    @(posedge clk);
    #1;
    if (env_on) begin
      fv_cnt      = fill_valve  ? fv_cnt + 1 : 0;
      dv_cnt      = drain_valve ? dv_cnt + 1 : 0;
      level_full  = (fv_cnt >= 2);
      level_empty = (dv_cnt >= 2);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    fv_cnt = 0; dv_cnt = 0;
    level_full = 1'b0; level_empty = 1'b0; pause = 1'b0; clear_err = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({fill_valve, drain_valve, motor_on, motor_fast, door_lock, busy, finish, error,
         err_code, phase} !== 14'd0)
      $display("FAIL reset_outputs: got %b expected all zero",
               {fill_valve, drain_valve, motor_on, motor_fast, door_lock, busy, finish,
                error, err_code, phase});
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    tick();
    n_checks++;
    if (phase !== 4'd0) $display("FAIL idle_hold: phase %0d expected 0", phase);
    else n_pass++;
  endtask

  task automatic run_normal(input string tag);
    int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 4, 5, 6, 7, 8, 0};
    int seq[$];
    int wash_len = 0, spin_len = 0, fin_cnt = 0;
    bit done = 1'b0, spin_checked = 1'b0, done_checked = 1'b0;
    env_on = 1'b1; clothes = 1'b1; det_liquid = 1'b1; water_tap = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (fill_valve !== 1'b1 || phase !== 4'd1)
      $display("FAIL %s start_to_fill: fill_valve %b phase %0d expected 1/1", tag, fill_valve, phase);
    else n_pass++;
    seq.push_back(int'(phase));
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      if (int'(phase) != seq[$]) seq.push_back(int'(phase));
      if (phase == 4'd2) wash_len++;
      if (phase == 4'd7) spin_len++;
      if (finish) fin_cnt++;
      if (phase == 4'd7 && !spin_checked) begin
        spin_checked = 1'b1;
        n_checks++;
        if ({motor_on, motor_fast, drain_valve, door_lock, busy} !== 5'b11111)
          $display("FAIL %s spin_outputs: got %b expected 11111", tag,
                   {motor_on, motor_fast, drain_valve, door_lock, busy});
        else n_pass++;
      end
      if (phase == 4'd8 && !done_checked) begin
        done_checked = 1'b1;
        n_checks++;
        if ({door_lock, busy, finish} !== 3'b001)
          $display("FAIL %s done_outputs: got %b expected 001", tag, {door_lock, busy, finish});
        else n_pass++;
      end
      if (phase == 4'd0) done = 1'b1;
    end
    n_checks++;
    if (!done) $display("FAIL %s run_timeout: programme did not return to IDLE in 200 cycles", tag);
    else n_pass++;
    n_checks++;
    if (seq.size() != 12) $display("FAIL %s seq_len: got %0d expected 12", tag, seq.size());
    else n_pass++;
    for (int i = 0; i < 12 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] != exp_seq[i])
        $display("FAIL %s seq[%0d]: got %0d expected %0d", tag, i, seq[i], exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (wash_len != 4) $display("FAIL %s wash_len: got %0d expected 4", tag, wash_len);
    else n_pass++;
    n_checks++;
    if (spin_len != 2) $display("FAIL %s spin_len: got %0d expected 2", tag, spin_len);
    else n_pass++;
    n_checks++;
    if (fin_cnt != 1) $display("FAIL %s finish_cycles: got %0d expected 1", tag, fin_cnt);
    else n_pass++;
    env_on = 1'b0;
  endtask

  task automatic test_normal();
    run_normal("normal");
  endtask

  task automatic test_no_water();
    level_empty = 1'b1; clothes = 1'b1; det_liquid = 1'b1; water_tap = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({phase, err_code, error, drain_valve, door_lock, busy} !== {4'd9, 2'b11, 1'b1, 3'b000})
      $display("FAIL no_water_error: got phase %0d err %b error %b dv %b lock %b busy %b expected 9 11 1 0 0 0",
               phase, err_code, error, drain_valve, door_lock, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (phase !== 4'd9 || err_code !== 2'b11)
      $display("FAIL no_water_hold: phase %0d err %b expected 9 11", phase, err_code);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if ({phase, err_code, error} !== {4'd0, 2'b00, 1'b0})
      $display("FAIL no_water_clear: phase %0d err %b error %b expected 0 00 0", phase, err_code, error);
    else n_pass++;
    water_tap = 1'b1;
  endtask

  task automatic test_fill_timeout();
    int fill_len = 1;
    level_full = 1'b0; level_empty = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (phase == 4'd1) fill_len++;
      else break;
    end
    n_checks++;
    if (fill_len != 5) $display("FAIL fill_tmo_len: got %0d expected 5", fill_len);
    else n_pass++;
    n_checks++;
    if ({phase, err_code, error, fill_valve, drain_valve, door_lock} !== {4'd9, 2'b01, 4'b1011})
      $display("FAIL fill_tmo_error: got phase %0d err %b error %b fv %b dv %b lock %b expected 9 01 1 0 1 1",
               phase, err_code, error, fill_valve, drain_valve, door_lock);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    n_checks++;
    if (phase !== 4'd9) $display("FAIL clear_needs_empty: phase %0d expected 9", phase);
    else n_pass++;
    level_empty = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (phase !== 4'd0 || err_code !== 2'b00)
      $display("FAIL fill_tmo_clear: phase %0d err %b expected 0 00", phase, err_code);
    else n_pass++;
    level_empty = 1'b0;
  endtask

  task automatic test_sensor_priority();
    level_full = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (phase !== 4'd1) $display("FAIL prio_still_fill: phase %0d expected 1", phase);
    else n_pass++;
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    n_checks++;
    if (phase !== 4'd2 || error !== 1'b0 || err_code !== 2'b00)
      $display("FAIL prio_sensor_wins: phase %0d error %b err %b expected 2 0 00", phase, error, err_code);
    else n_pass++;
    pulse_reset();
  endtask

  task automatic test_reset_midrun();
    int rinse_seen = 0;
    int last = 0;
    env_on = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && rinse_seen < 2; cyc++) begin
      tick();
      if (phase == 4'd5 && last != 5) rinse_seen++;
      last = int'(phase);
    end
    n_checks++;
    if (rinse_seen != 2) $display("FAIL reset_reach_rinse: saw %0d rinses expected 2", rinse_seen);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({fill_valve, drain_valve, motor_on, motor_fast, door_lock, busy, finish, error,
         err_code, phase} !== 14'd0)
      $display("FAIL async_reset_outputs: got %b expected all zero",
               {fill_valve, drain_valve, motor_on, motor_fast, door_lock, busy, finish,
                error, err_code, phase});
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    env_on = 1'b0; fv_cnt = 0; dv_cnt = 0; level_full = 1'b0; level_empty = 1'b0;
    run_normal("after_reset");
  endtask

  task automatic test_pause();
    int widx = 0, motor_off = 0;
    bit left = 1'b0;
`ifdef WM_PAUSE_EN
    int exp_len = 7, exp_off = 3;
`else
    int exp_len = 4, exp_off = 0;
`endif
    env_on = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 60 && !left; cyc++) begin
      tick();
      if (phase == 4'd2) begin
        widx++;
        pause = (widx >= 2 && widx <= 4);
        #1;
        if (!motor_on) motor_off++;
      end else begin
        pause = 1'b0;
        if (widx > 0) left = 1'b1;
      end
    end
    n_checks++;
    if (!left) $display("FAIL pause_timeout: WASH not left within 60 cycles");
    else n_pass++;
    n_checks++;
    if (widx != exp_len) $display("FAIL pause_wash_len: got %0d expected %0d", widx, exp_len);
    else n_pass++;
    n_checks++;
    if (motor_off != exp_off) $display("FAIL pause_motor_off: got %0d expected %0d", motor_off, exp_off);
    else n_pass++;
    env_on = 1'b0;
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_no_water();
    test_fill_timeout();
    test_sensor_priority();
    test_reset_midrun();
    test_pause();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

Programme controller for a single washing-machine drum: sequences fill, wash, drain, rinse (repeated), spin and completion, and drives the water valves, drain valve, motor and door lock. Sits between the front-panel/sensor inputs and the actuator drivers. It replaces ad-hoc phase counting with explicit level-sensor handshakes, fill/drain timeouts, a programmable rinse count and error latching.

## Interface
- CNT_W, 8: width of the shared phase/timeout timer.
- WASH_CYC, 30: wash agitation duration in cycles, 1..2^CNT_W-1.
- RINSE_CYC, 30: duration of each rinse agitation, 1..2^CNT_W-1.
- SPIN_CYC, 30: spin duration, 1..2^CNT_W-1.
- N_RINSE, 2: rinse passes, 1..3.
- FILL_TMO, 100: maximum cycles in any fill or drain state before an error, 1..2^CNT_W-1.
- clk in 1: clock.
- rst in 1: reset. **Asynchronous, active-high.**
- start in 1: request a programme. Sampled only in IDLE.
- clothes in 1: drum loaded.
- det_liquid in 1: detergent present.
- water_tap in 1: supply tap open.
- level_full in 1: drum-full sensor.
- level_empty in 1: drum-empty sensor.
- pause in 1: hold agitation. Effective only with the macro defined.
- clear_err in 1: leave ERROR.
- fill_valve out 1: water inlet open.
- drain_valve out 1: drain pump on.
- motor_on out 1: drum motor running.
- motor_fast out 1: spin speed selected.
- door_lock out 1: door locked.
- busy out 1: programme in progress (any state except IDLE, DONE and ERROR).
- finish out 1: one-cycle pulse on completion.
- error out 1: high while in ERROR.
- err_code out 2: error cause.
  - 00: none.
  - 01: fill timeout.
  - 10: drain timeout.
  - 11: no water at start.
- phase out 4: current state code.

## Operation
- State codes:
  - IDLE=0, FILL_W=1, WASH=2, DRAIN_W=3, FILL_R=4, RINSE=5, DRAIN_R=6, SPIN=7, DONE=8, ERROR=9.
- IDLE transitions:
  - start & clothes & det_liquid & water_tap → FILL_W.
  - start & clothes & det_liquid & !water_tap → ERROR with err_code=11.
  - Anything else: stay in IDLE.
- FILL_W and FILL_R:
  - fill_valve=1.
  - level_full → WASH (from FILL_W) or RINSE (from FILL_R).
  - Timer reaching FILL_TMO-1 without level_full → ERROR, err_code=01.
- WASH, RINSE and SPIN:
  - motor_on=1.
  - Exit when the timer reaches DUR-1. WASH → DRAIN_W, RINSE → DRAIN_R, SPIN → DONE.
- DRAIN_W and DRAIN_R:
  - drain_valve=1.
  - level_empty → FILL_R.
  - Exception: DRAIN_R with rinse_cnt==N_RINSE-1 goes to SPIN instead.
  - DRAIN_R increments rinse_cnt when it exits to FILL_R.
  - Timeout as for fill, but err_code=10.
- SPIN: drain_valve=1, motor_on=1, motor_fast=1.
- DONE: finish=1 for exactly one cycle, then IDLE. rinse_cnt is cleared.
- ERROR:
  - All actuators off except drain_valve=1 while !level_empty.
  - door_lock stays 1 until level_empty.
  - clear_err & level_empty → IDLE and err_code=00.
  - err_code is held throughout ERROR.
- door_lock=1 in every state except IDLE and DONE, and in ERROR it follows the rule above.
- Timer and rinse_cnt handling:
  - The timer clears on every state change.
  - Otherwise it increments and saturates at 2^CNT_W-1.
  - rinse_cnt is 2 bits.
- Sensor priority: if level_full/level_empty and the timeout condition are true on the same cycle, the sensor wins and there is no error.
- Mid-programme input changes: clothes, det_liquid and water_tap are ignored outside IDLE.

## Timing
- Outputs are a Moore decode of the registered state (plus level_empty in ERROR). They change on the edge after the transition condition.
- Phase lengths:
  - Timed phases: exactly DUR cycles in the state.
  - Fill/drain phases: 1 cycle after the sensor is seen.
- start → fill_valve=1: 1 cycle.
- Reset:
  - rst asserts at any time, mid-programme included → immediately state=IDLE, timer=0, rinse_cnt=0, err_code=00.
  - Every output is 0 during reset.

## Configuration
- WM_PAUSE_EN defined:
  - pause high in WASH, RINSE or SPIN freezes the timer and forces motor_on=0 and motor_fast=0. The state is held and the timer resumes from the frozen value when pause drops.
  - pause is ignored in all other states.
- WM_PAUSE_EN undefined: pause has no effect and no pause logic exists.

## Test plan
- Normal run with WASH_CYC=4, RINSE_CYC=3, SPIN_CYC=2, N_RINSE=2, full/empty returned 2 cycles after the valve opens:
  - phase sequence 1,2,3,4,5,6,4,5,6,7,8,0.
  - WASH lasts exactly 4 cycles, SPIN exactly 2.
  - finish is high for 1 cycle.
- start with water_tap=0 → phase=9, err_code=11, error=1.
  - clear_err with level_empty=1 → IDLE next cycle.
- FILL_TMO=5 with level_full never asserted → ERROR on cycle 5 of FILL_W, err_code=01, fill_valve=0.
- level_full asserted on the cycle the timer hits FILL_TMO-1 → WASH, no error.
- rst pulsed in RINSE → all outputs 0 at once; a later start runs the full programme with rinse_cnt counted from 0.
- With WM_PAUSE_EN, WASH_CYC=4, pause high for 3 cycles after wash cycle 2 → motor_on low for those 3 cycles, WASH total 7 cycles. Without the macro, WASH stays 4 cycles.
